// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU operand-path constants and feeder state encoding
package tpu_pkg;

    localparam int TPU_AWIDTH      = 10;
    localparam int TPU_DWIDTH      = 8;
    localparam int TPU_DESIGN_SIZE = 16;

    // Width of one Q5.3 lane inside a packed RAM word
    localparam int LANE_W = TPU_DWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage data+valid shift register; DEPTH=0 is a straight wire
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_shift
            logic [DWIDTH-1:0] data_sr [DEPTH];
            logic [DEPTH-1:0]  valid_sr;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        data_sr[j] <= '0;
                    end
                    valid_sr <= '0;
                end else begin
                    data_sr[0]  <= in_data;
                    valid_sr[0] <= in_valid;
                    for (int j = 1; j < DEPTH; j++) begin
                        data_sr[j]  <= data_sr[j-1];
                        valid_sr[j] <= valid_sr[j-1];
                    end
                end
            end

            assign out_data  = data_sr[DEPTH-1];
            assign out_valid = valid_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ram_skew_feeder.sv
// rtl/ram_skew_feeder.sv - fetches a block of RAM rows and skews lanes into a systolic wavefront
module ram_skew_feeder
    import tpu_pkg::*;
#(
    parameter int AWIDTH      = TPU_AWIDTH,
    parameter int DWIDTH      = TPU_DWIDTH,
    parameter int DESIGN_SIZE = TPU_DESIGN_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [AWIDTH-1:0]             num_rows,
    input  logic [AWIDTH-1:0]             addr_stride,
    output logic [AWIDTH-1:0]             ram_addr,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic [DESIGN_SIZE-1:0]        out_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int CNT_W = $clog2(DESIGN_SIZE + 3);

    feeder_state_t                 state;
    logic [AWIDTH-1:0]             stride;
    logic [AWIDTH-1:0]             rows_left;
    logic                          zero_job;
    logic [CNT_W-1:0]              drain_cnt;
    logic                          rd_v;
    logic [DESIGN_SIZE*DWIDTH-1:0] cap_data;
    logic                          cap_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stride    <= '0;
            rows_left <= '0;
            zero_job  <= 1'b0;
            drain_cnt <= '0;
            ram_addr  <= '0;
            rd_v      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_v <= (state == READ);
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        stride    <= addr_stride;
                        rows_left <= num_rows;
                        zero_job  <= (num_rows == '0);
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        if (num_rows != '0) begin
                            ram_addr <= base_addr;
                            state    <= READ;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                READ: begin
                    rows_left <= rows_left - 1'b1;
                    if (rows_left == AWIDTH'(1)) begin
                        state <= DRAIN;
                    end else begin
                        ram_addr <= ram_addr + stride;
                    end
                end
                DRAIN: begin
                    // Wait out RAM latency, capture and the longest skew line before done
                    if (done) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        done      <= zero_job || (drain_cnt == CNT_W'(DESIGN_SIZE + 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_data  <= rd_v ? ram_q : '0;
            cap_valid <= rd_v;
        end
    end

    // Lane 0 leaves straight from the capture stage; lane i adds i stages
    assign out_data[DWIDTH-1:0] = cap_data[DWIDTH-1:0];
    assign out_valid[0]         = cap_valid;

    generate
        for (genvar i = 1; i < DESIGN_SIZE; i++) begin : g_lane
            skew_delay_line #(
                .DEPTH (i),
                .DWIDTH(DWIDTH)
            ) u_skew (
                .clk      (clk),
                .reset    (reset),
                .in_data  (cap_data[i*DWIDTH +: DWIDTH]),
                .in_valid (cap_valid),
                .out_data (out_data[i*DWIDTH +: DWIDTH]),
                .out_valid(out_valid[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_skew_feeder.sv
// tb/tb_ram_skew_feeder.sv - randomized self-checking bench for ram_skew_feeder
module tb_ram_skew_feeder;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DS = 16;
    localparam int W  = DS * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic [AW-1:0] addr_stride;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_q;
    logic [W-1:0]  out_data;
    logic [DS-1:0] out_valid;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem [1024];
    logic [AW-1:0] last_addr;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    ram_skew_feeder #(.AWIDTH(AW), .DWIDTH(DW), .DESIGN_SIZE(DS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .addr_stride(addr_stride),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int k);
        logic [AW-1:0] a;
        a = base;
        for (int j = 0; j < k; j++) a = a + stride;
        return a;
    endfunction

    // Expected outputs are derived from the job's row schedule: lane i shows row k at c0+k+2+i
    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] n,
                           input logic [AW-1:0] stride, input int junk_t);
        int            d;
        int            nr;
        logic [W-1:0]  ed;
        logic [DS-1:0] ev;
        logic [AW-1:0] a;
        nr = int'(n);
        d  = (nr == 0) ? 1 : nr + 2 + DS;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_rows = n; addr_stride = stride;
        @(negedge clk);
        start = 1'b0; base_addr = AW'($urandom); num_rows = AW'($urandom); addr_stride = AW'($urandom);
        for (int t = 0; t <= d; t++) begin
            if (t > 0) @(negedge clk);
            ed = '0;
            ev = '0;
            for (int i = 0; i < DS; i++) begin
                int k;
                k = t - 2 - i;
                if (k >= 0 && k < nr) begin
                    ev[i] = 1'b1;
                    a = row_addr(base, stride, k);
                    ed[i*DW +: DW] = mem[a][i*DW +: DW];
                end
            end
            if (nr == 0) a = last_addr;
            else         a = row_addr(base, stride, (t < nr) ? t : nr - 1);
            check("ram_addr", W'(ram_addr), W'(a));
            check("out_data", out_data, ed);
            check("out_valid", W'(out_valid), W'(ev));
            check("busy", W'(busy), W'(1'b1));
            check("done", W'(done), W'(t == d));
            if (t == junk_t) begin
                start = 1'b1; base_addr = AW'($urandom);
                num_rows = AW'($urandom_range(1, 5)); addr_stride = AW'($urandom);
            end else if (t == junk_t + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (nr != 0) last_addr = row_addr(base, stride, nr - 1);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("idle_busy", W'(busy), W'(1'b0));
            check("idle_done", W'(done), W'(1'b0));
            check("idle_valid", W'(out_valid), W'(0));
            check("idle_addr", W'(ram_addr), W'(last_addr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, W'(ram_addr), W'(0));
        check({tag, "_data"}, out_data, '0);
        check({tag, "_valid"}, W'(out_valid), W'(0));
        check({tag, "_busy"}, W'(busy), W'(1'b0));
        check({tag, "_done"}, W'(done), W'(1'b0));
    endtask

    initial begin
        int n;
        int d;
        int junk;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; addr_stride = '0;
        last_addr = '0;
        for (int a = 0; a < 1024; a++) begin
            for (int i = 0; i < DS; i++) mem[a][i*DW +: DW] = DW'($urandom);
        end
        for (int r = 5; r <= 7; r++) begin
            for (int i = 0; i < DS; i++) mem[r][i*DW +: DW] = DW'(4 * (i + 1) + r);
        end
        for (int r = 100; r <= 103; r++) begin
            for (int i = 0; i < DS; i++) mem[r][i*DW +: DW] = DW'(8'hFC - 4 * i);
        end

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        idle(1);

        run_job(10'd5, 10'd3, 10'd1, -1);
        idle(2);
        run_job(10'h3FE, 10'd3, 10'd2, -1);
        run_job(10'h123, 10'd0, 10'd7, -1);
        idle(1);
        run_job(10'd20, 10'd4, 10'd3, 10);
        run_job(10'd40, 10'd2, 10'd5, -1);
        idle(2);

        // Abort a job mid-READ with an asynchronous reset between edges
        @(negedge clk);
        start = 1'b1; base_addr = 10'd5; num_rows = 10'd3; addr_stride = 10'd1;
        @(negedge clk);
        start = 1'b0;
        check("abort_c0_addr", W'(ram_addr), W'(10'd5));
        @(negedge clk);
        check("abort_c1_addr", W'(ram_addr), W'(10'd6));
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        reset = 1'b0;
        last_addr = '0;
        idle(25);
        run_job(10'd5, 10'd3, 10'd1, -1);
        idle(1);

        run_job(10'd100, 10'd4, 10'd1, -1);

        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(0, 8);
            d = (n == 0) ? 1 : n + 2 + DS;
            junk = ($urandom_range(0, 1) == 1) ? n + int'($urandom_range(0, d - 1 - n)) : -1;
            run_job(AW'($urandom), AW'(n), AW'($urandom), junk);
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
